fp16_add_arb: RTL and testbench
===============================

# fp16_add_arb

Round-robin arbiter and scheduler that shares one fixed-latency fp16 adder among `NUM_REQ` independent requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The arbiter issues one operation per cycle to the shared adder and tracks the requester ID through a tag pipeline matched to the adder latency.
- It returns each sum to the originating requester through a held response register with its own valid/ready handshake.
- It sits between the compute clients and the single `fp16_add` instance; it never inspects or modifies operand values.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, range 2..8.
- `ADD_LATENCY`, 2: cycles from `add_a`/`add_b` presented to matching `add_result` valid. 0 means a combinational adder.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester operation request.
- `req_ready` out NUM_REQ: per-requester grant; a handshake is `req_valid[i] & req_ready[i]`.
- `req_a` in 16*NUM_REQ: operand A, requester i at bits [16i+15:16i].
- `req_b` in 16*NUM_REQ: operand B, same packing as `req_a`.
- `rsp_valid` out NUM_REQ: per-requester result available.
- `rsp_ready` in NUM_REQ: per-requester result accept.
- `rsp_result` out 16*NUM_REQ: per-requester sum, same packing as `req_a`.
- `add_a` out 16: operand A to the shared adder, registered.
- `add_b` out 16: operand B to the shared adder, registered.
- `add_issue` out 1: high when `add_a`/`add_b` carry a live operation, registered.
- `add_result` in 16: adder output, valid `ADD_LATENCY` cycles after the matching issue.

## Operation
- **Eligibility:** `elig[i] = req_valid[i] & ~busy[i]`. Each requester has at most one operation outstanding.
- **Arbitration:** round-robin over `elig`.
  - The search starts at pointer `ptr` and wraps modulo NUM_REQ.
  - The first eligible index wins and receives a one-hot `req_ready`.
  - `req_ready` is combinational from `req_valid`, `busy` and `ptr`; it is all-zero when no requester is eligible.
- **On a grant to index g (at the clock edge):**
  - `ptr <= (g+1) mod NUM_REQ`.
  - `busy[g] <= 1`.
  - `add_a <= req_a[g]`, `add_b <= req_b[g]`, `add_issue <= 1`.
  - Tag pipeline stage 0 is loaded with {valid=1, id=g}.
- **No grant:** `add_issue <= 0`; `add_a`/`add_b` hold their last values; `ptr` holds; stage 0 valid is 0.
- **Tag pipeline:**
  - Depth `ADD_LATENCY+1`, shifting every cycle with no stall.
  - When the last stage is valid with id k, `add_result` is captured into `rsp_result[k]` and `rsp_valid[k] <= 1` at that edge.
- **Response handshake:** the edge with `rsp_valid[k] & rsp_ready[k]` clears `rsp_valid[k]` and `busy[k]`. `rsp_result[k]` holds its value until it is overwritten.
- **Slot safety:** capture into slot k never collides with a pending response in slot k, because `busy[k]` blocks reissue until the response handshake completes.
- **Same-edge response and request:** if a response handshake and a new request from the same requester occur on the same edge, the request is not granted that cycle; it becomes eligible the following cycle.
- **Reset mid-operation:** all in-flight tags are discarded and no `rsp_valid` rises afterwards for them.

## Timing
- **Reset values:**
  - `req_ready`, `rsp_valid`, `add_issue`: 0.
  - `add_a`, `add_b`, `rsp_result`: 0.
  - `busy`: 0; `ptr`: 0; all tag valids: 0.
- **Latency:** handshake in cycle 0 → `add_issue`/`add_a`/`add_b` in cycle 1 → `add_result` in cycle 1+ADD_LATENCY → `rsp_valid` in cycle 2+ADD_LATENCY. This is cycle 4 at the default latency.
- **Throughput:** aggregate one issue per cycle. A single requester issues at most once per 3+ADD_LATENCY cycles when `rsp_ready` is tied high.
- **Stability:** `rsp_valid`/`rsp_result` are stable while `rsp_ready` is low. `req_ready` never asserts without `req_valid`.
- **Fairness:** a requester that stays eligible is granted within NUM_REQ cycles.
- **Response ordering:** responses leave the pipeline in issue order; each slot is consumed independently.

## Test plan
All scenarios use `ADD_LATENCY`=2.
- **Single request:** req0 with a=0x3C00 (1.0), b=0x4000 (2.0) in cycle 0 → `req_ready[0]`=1 in cycle 0; `add_issue`=1 with `add_a`=0x3C00 in cycle 1; `rsp_valid[0]`=1 with `rsp_result[0]`=0x4200 in cycle 4.
- **All requesters at once:** all four requesters valid in the same cycle after reset → grants 0,1,2,3 on four consecutive cycles; `add_issue` high 4 cycles; `rsp_valid` rises for 0,1,2,3 in cycles 4,5,6,7.
- **Round-robin order:** after a grant to 0 (`ptr`=1), req0 and req3 are both valid → req3 granted first, req0 the next cycle.
- **Response backpressure:** `rsp_ready[1]`=0 for 10 cycles with `req_valid[1]` held → `rsp_valid[1]` and `rsp_result[1]` stay stable, `req_ready[1]`=0 throughout, and other requesters keep issuing. One cycle after `rsp_ready[1]` rises, req1 is granted again.
- **Reset mid-flight:** assert `rst` one cycle with 3 operations in the tag pipeline → the next cycle every output is 0, no `rsp_valid` appears for 10 cycles, and a new request then completes with the normal 4-cycle latency.
- **Combinational adder:** rerun the single-request scenario with `ADD_LATENCY`=0 → `rsp_valid[0]` in cycle 2 with the correct sum.

Source files
------------

// File: rtl/fp16_add_arb.sv
// fp16_add_arb: round-robin arbiter sharing one fixed-latency fp16 adder among NUM_REQ requesters.
// Requester IDs ride a tag pipeline matched to the adder latency so each sum returns to its owner.
module fp16_add_arb #(
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [16*NUM_REQ-1:0] rsp_result,
    output logic [15:0]           add_a,
    output logic [15:0]           add_b,
    output logic                  add_issue,
    input  logic [15:0]           add_result
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int D  = ADD_LATENCY + 1;

    logic [NUM_REQ-1:0]    busy_q, busy_d, elig, cap, rsp_valid_q, rsp_valid_d;
    logic [IW-1:0]         ptr_q, gnt_id, idx;
    logic                  gnt_vld, add_issue_q;
    logic                  tag_v_q [D];
    logic [IW-1:0]         tag_id_q [D];
    logic [16*NUM_REQ-1:0] rsp_result_q;
    logic [15:0]           add_a_q, add_b_q;

    assign elig = req_valid & ~busy_q;

    // Scan from the farthest slot back to ptr so the nearest eligible index wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr_q) + k) % NUM_REQ);
            if (elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx;
            end
        end
    end

    assign req_ready   = gnt_vld ? (NUM_REQ'(1) << gnt_id) : '0;
    assign cap         = tag_v_q[D-1] ? (NUM_REQ'(1) << tag_id_q[D-1]) : '0;
    assign busy_d      = (busy_q | req_ready) & ~(rsp_valid_q & rsp_ready);
    assign rsp_valid_d = (rsp_valid_q & ~rsp_ready) | cap;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            ptr_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            add_issue_q  <= 1'b0;
            for (int s = 0; s < D; s++) tag_v_q[s] <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            add_issue_q <= gnt_vld;
            tag_v_q[0]  <= gnt_vld;
            for (int s = 1; s < D; s++) tag_v_q[s] <= tag_v_q[s-1];
            if (gnt_vld) begin
                ptr_q   <= (gnt_id == IW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
                add_a_q <= req_a[16*gnt_id +: 16];
                add_b_q <= req_b[16*gnt_id +: 16];
            end
            if (tag_v_q[D-1]) rsp_result_q[16*tag_id_q[D-1] +: 16] <= add_result;
        end
    end

    always_ff @(posedge clk) begin
        tag_id_q[0] <= gnt_id;
        for (int s = 1; s < D; s++) tag_id_q[s] <= tag_id_q[s-1];
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign add_issue  = add_issue_q;
endmodule

// File: tb/tb_fp16_add_arb.sv
// tb_fp16_add_arb: scenario tasks plus a randomized run against a cycle-level model of the arbiter.
// Two instances: the default two-stage adder and a combinational adder.
module tb_fp16_add_arb;
    localparam int N = 4;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [16*N-1:0] req_a, req_b, rsp_result;
    logic [15:0]     add_a, add_b, add_result, p1, p2;
    logic            add_issue;
    logic [N-1:0]    req_valid0, req_ready0, rsp_valid0, rsp_ready0;
    logic [16*N-1:0] req_a0, req_b0, rsp_result0;
    logic [15:0]     add_a0, add_b0, add_result0;
    logic            add_issue0;
    int n_tests = 0, n_fail = 0;

    function automatic real h2r(input logic [15:0] h);
        real r;
        if (h[14:0] == 15'd0) return 0.0;
        r = 1.0 + real'(h[9:0]) / 1024.0;
        for (int e = int'(h[14:10]); e > 15; e--) r = r * 2.0;
        for (int e = int'(h[14:10]); e < 15; e++) r = r / 2.0;
        return h[15] ? -r : r;
    endfunction

    // Normal-range results only; operands are drawn so sums never go subnormal.
    function automatic logic [15:0] r2h(input real r);
        logic [63:0] d;
        logic [14:0] mag;
        logic up;
        if (r == 0.0) return 16'h0000;
        d   = $realtobits(r);
        mag = {5'(int'(d[62:52]) - 1008), d[51:42]};
        up  = d[41] && (d[40:0] != 41'd0 || d[42]);
        return {d[63], mag + 15'(up)};
    endfunction

    function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
        return r2h(h2r(a) + h2r(b));
    endfunction

    function automatic logic [15:0] rnd_h();
        return {1'($urandom), 5'($urandom_range(20, 14)), 10'($urandom)};
    endfunction

    always @(posedge clk) begin
        p1 <= fadd(add_a, add_b);
        p2 <= p1;
    end
    assign add_result  = p2;
    assign add_result0 = fadd(add_a0, add_b0);

    fp16_add_arb #(.NUM_REQ(N), .ADD_LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .add_a(add_a), .add_b(add_b), .add_issue(add_issue),
        .add_result(add_result));

    fp16_add_arb #(.NUM_REQ(N), .ADD_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_a(req_a0), .req_b(req_b0), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_result(rsp_result0), .add_a(add_a0), .add_b(add_b0), .add_issue(add_issue0),
        .add_result(add_result0));

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; rsp_ready = '1; req_valid0 = '0; rsp_ready0 = '1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = '0; rsp_ready = '0; req_valid0 = '0; rsp_ready0 = '0;
        req_a = '1; req_b = '1; req_a0 = '1; req_b0 = '1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_tests++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %h want 0", req_ready); end
        n_tests++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid: got %h want 0", rsp_valid); end
        n_tests++; if (add_issue !== 1'b0) begin n_fail++; $display("FAIL reset_add_issue: got %b want 0", add_issue); end
        n_tests++; if ({add_a, add_b} !== 32'd0) begin n_fail++; $display("FAIL reset_add_ab: got %h %h want 0", add_a, add_b); end
        n_tests++; if (rsp_result !== '0) begin n_fail++; $display("FAIL reset_rsp_result: got %h want 0", rsp_result); end
        n_tests++; if ({rsp_valid0, add_issue0, add_a0} !== '0) begin n_fail++; $display("FAIL reset_dut0: got %h %b %h want 0", rsp_valid0, add_issue0, add_a0); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0001; req_a[15:0] = 16'h3C00; req_b[15:0] = 16'h4000;
        #1;
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_tests++; if ({add_issue, add_a, add_b} !== {1'b1, 16'h3C00, 16'h4000})
            begin n_fail++; $display("FAIL single_issue: got %b %h %h want 1 3c00 4000", add_issue, add_a, add_b); end
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            #1;
            n_tests++; if (rsp_valid !== ((c == 4) ? 4'b0001 : 4'b0000))
                begin n_fail++; $display("FAIL single_rsp_valid c%0d: got %b", c, rsp_valid); end
        end
        n_tests++; if (rsp_result[15:0] !== 16'h4200) begin n_fail++; $display("FAIL single_sum: got %h want 4200", rsp_result[15:0]); end
    endtask

    task automatic test_all();
        logic [15:0] s[N];
        logic [N-1:0] rem = '1;
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_a[16*i +: 16] = rnd_h(); req_b[16*i +: 16] = rnd_h();
            s[i] = fadd(req_a[16*i +: 16], req_b[16*i +: 16]);
        end
        for (int c = 0; c < 9; c++) begin
            req_valid = rem;
            #1;
            if (c < 4) begin
                n_tests++; if (req_ready !== (N'(1) << c)) begin n_fail++; $display("FAIL all_grant c%0d: got %b", c, req_ready); end
            end
            rem = rem & ~req_ready;
            n_tests++; if (add_issue !== (c >= 1 && c <= 4)) begin n_fail++; $display("FAIL all_issue c%0d: got %b", c, add_issue); end
            n_tests++; if (rsp_valid !== ((c >= 4 && c < 8) ? N'(1) << (c - 4) : N'(0)))
                begin n_fail++; $display("FAIL all_rsp_valid c%0d: got %b", c, rsp_valid); end
            if (c >= 4 && c < 8) begin
                n_tests++; if (rsp_result[16*(c-4) +: 16] !== s[c-4])
                    begin n_fail++; $display("FAIL all_sum %0d: got %h want %h", c - 4, rsp_result[16*(c-4) +: 16], s[c-4]); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rr();
        do_reset();
        for (int c = 0; c < 13; c++) begin
            req_valid = (c == 0) ? 4'b0001 : (c == 5 || c == 6) ? 4'b1001 : 4'b0000;
            #1;
            if (c == 5) begin
                n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL rr_first: got %b want 1000", req_ready); end
            end
            if (c == 6) begin
                n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_second: got %b want 0001", req_ready); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] s1;
        int n_iss = 0;
        do_reset();
        for (int i = 0; i < N; i++) begin req_a[16*i +: 16] = rnd_h(); req_b[16*i +: 16] = rnd_h(); end
        s1 = fadd(req_a[31:16], req_b[31:16]);
        for (int c = 0; c < 25; c++) begin
            req_valid = (c < 12) ? 4'b1111 : (c < 17) ? 4'b0010 : 4'b0000;
            rsp_ready = (c < 15) ? 4'b1101 : 4'b1111;
            #1;
            if (c >= 5 && c <= 14) begin
                n_tests++; if ({rsp_valid[1], rsp_result[31:16]} !== {1'b1, s1})
                    begin n_fail++; $display("FAIL bp_hold c%0d: got %b %h want 1 %h", c, rsp_valid[1], rsp_result[31:16], s1); end
                n_tests++; if (req_ready[1] !== 1'b0) begin n_fail++; $display("FAIL bp_no_grant c%0d: got %b", c, req_ready); end
                if (c >= 6 && add_issue) n_iss++;
            end
            if (c == 15) begin
                n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_same_edge: got %b want 0000", req_ready); end
            end
            if (c == 16) begin
                n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_regrant: got %b want 0010", req_ready); end
            end
            @(negedge clk);
        end
        n_tests++; if (n_iss < 2) begin n_fail++; $display("FAIL bp_others_issue: got %0d issues want >=2", n_iss); end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] rem = 4'b0111;
        logic [15:0] s2;
        do_reset();
        for (int i = 0; i < N; i++) begin req_a[16*i +: 16] = rnd_h(); req_b[16*i +: 16] = rnd_h(); end
        for (int c = 0; c < 3; c++) begin
            req_valid = rem;
            #1;
            rem = rem & ~req_ready;
            @(negedge clk);
        end
        req_valid = '0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++; if ({req_ready, rsp_valid, add_issue, add_a, add_b, rsp_result} !== '0)
            begin n_fail++; $display("FAIL mid_reset_outputs: got %b %b %b %h %h %h", req_ready, rsp_valid, add_issue, add_a, add_b, rsp_result); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            n_tests++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL mid_reset_ghost c%0d: got %b", c, rsp_valid); end
        end
        @(negedge clk);
        req_valid = 4'b0100;
        s2 = fadd(req_a[47:32], req_b[47:32]);
        #1;
        n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL mid_reset_grant: got %b want 0100", req_ready); end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            n_tests++; if (rsp_valid !== ((c == 4) ? 4'b0100 : 4'b0000)) begin n_fail++; $display("FAIL mid_reset_lat c%0d: got %b", c, rsp_valid); end
        end
        n_tests++; if (rsp_result[47:32] !== s2) begin n_fail++; $display("FAIL mid_reset_sum: got %h want %h", rsp_result[47:32], s2); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_comb();
        do_reset();
        req_valid0 = 4'b0001; req_a0[15:0] = 16'h3C00; req_b0[15:0] = 16'h4000;
        #1;
        n_tests++; if (req_ready0 !== 4'b0001) begin n_fail++; $display("FAIL comb_grant: got %b want 0001", req_ready0); end
        @(negedge clk);
        req_valid0 = '0;
        #1;
        n_tests++; if ({add_issue0, add_a0, rsp_valid0} !== {1'b1, 16'h3C00, 4'b0000})
            begin n_fail++; $display("FAIL comb_issue: got %b %h %b", add_issue0, add_a0, rsp_valid0); end
        @(negedge clk);
        #1;
        n_tests++; if ({rsp_valid0, rsp_result0[15:0]} !== {4'b0001, 16'h4200})
            begin n_fail++; $display("FAIL comb_rsp: got %b %h want 0001 4200", rsp_valid0, rsp_result0[15:0]); end
        @(negedge clk);
        #1;
        n_tests++; if (rsp_valid0 !== '0) begin n_fail++; $display("FAIL comb_rsp_clear: got %b", rsp_valid0); end
    endtask

    // Model: per-requester outstanding flag, grant cycle and expected sum; round-robin from a pointer.
    task automatic test_random();
        logic [N-1:0] out_m = '0, rv_m, rdy_m;
        int gcyc[N], ptr_m = 0, g;
        logic [15:0] esum[N], ia_m = '0, ib_m = '0;
        logic iss_m = 1'b0;
        for (int i = 0; i < N; i++) begin gcyc[i] = 0; esum[i] = '0; end
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) rv_m[i] = out_m[i] && (c >= gcyc[i] + 4);
            n_tests++; if (rsp_valid !== rv_m) begin n_fail++; $display("FAIL rand_rsp_valid c%0d: got %b want %b", c, rsp_valid, rv_m); end
            for (int i = 0; i < N; i++)
                if (rv_m[i]) begin
                    n_tests++; if (rsp_result[16*i +: 16] !== esum[i])
                        begin n_fail++; $display("FAIL rand_sum c%0d r%0d: got %h want %h", c, i, rsp_result[16*i +: 16], esum[i]); end
                end
            n_tests++; if (add_issue !== iss_m || (iss_m && {add_a, add_b} !== {ia_m, ib_m}))
                begin n_fail++; $display("FAIL rand_issue c%0d: got %b %h %h want %b %h %h", c, add_issue, add_a, add_b, iss_m, ia_m, ib_m); end
            req_valid = N'($urandom);
            rsp_ready = N'($urandom);
            for (int i = 0; i < N; i++) begin req_a[16*i +: 16] = rnd_h(); req_b[16*i +: 16] = rnd_h(); end
            #1;
            g = -1;
            for (int k = 0; k < N && g < 0; k++)
                if (req_valid[(ptr_m + k) % N] && !out_m[(ptr_m + k) % N]) g = (ptr_m + k) % N;
            rdy_m = (g < 0) ? N'(0) : N'(1) << g;
            n_tests++; if (req_ready !== rdy_m) begin n_fail++; $display("FAIL rand_grant c%0d: got %b want %b", c, req_ready, rdy_m); end
            out_m = out_m & ~(rv_m & rsp_ready);
            iss_m = (g >= 0);
            if (iss_m) begin
                out_m[g] = 1'b1; gcyc[g] = c; ptr_m = (g + 1) % N;
                ia_m = req_a[16*g +: 16]; ib_m = req_b[16*g +: 16];
                esum[g] = fadd(ia_m, ib_m);
            end
            @(negedge clk);
        end
        req_valid = '0; rsp_ready = '1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
        req_valid0 = '0; rsp_ready0 = '0; req_a0 = '0; req_b0 = '0;
        test_reset();
        test_single();
        test_all();
        test_rr();
        test_backpressure();
        test_reset_mid();
        test_comb();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
